// File: rtl/fifo_pkg.sv
// Shared definitions for the read-side FIFO nibble drain.
package fifo_pkg;

    localparam int unsigned D_WIDTH_DEF       = 4;
    localparam int unsigned A_WIDTH_DEF       = 4;
    localparam int unsigned FLUSH_TIMEOUT_DEF = 16;

    // LO: no nibble held; HI: low nibble held; HOLD: byte presented downstream
    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        ST_HI   = 2'd1,
        ST_HOLD = 2'd2
    } drain_state_t;

endpackage

// File: rtl/drain_timeout_ctr.sv
// Idle-cycle counter for the drain; flags the cycle on which the flush timeout expires.
module drain_timeout_ctr #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned W     = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    localparam logic [W-1:0] TERM_VAL = W'((LIMIT == 0) ? 0 : LIMIT - 1);
    localparam logic [W-1:0] SAT_VAL  = W'(LIMIT);

    logic [W-1:0] count;

    // Clear wins over increment; the count saturates at LIMIT so it never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count < SAT_VAL)) begin
            count <= count + W'(1);
        end
    end

    // Terminal count: the current cycle is the LIMIT-th consecutive idle cycle
    always_comb begin
        terminal = (LIMIT != 0) && (count == TERM_VAL);
    end

endmodule

// File: rtl/fifo_nibble_drain.sv
// Read-side FIFO consumer: packs nibble pairs into bytes, flushing a lone
// low nibble as a partial byte after an idle timeout.
module fifo_nibble_drain
    import fifo_pkg::*;
#(
    parameter int unsigned D_WIDTH       = D_WIDTH_DEF,
    parameter int unsigned FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [D_WIDTH-1:0]     fifo_rdata,
    output logic                   fifo_rinc,
    output logic [2*D_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_partial,
    output logic [CNT_WIDTH-1:0]   byte_count
);

    drain_state_t       state;
    drain_state_t       state_nx;
    logic [D_WIDTH-1:0] lo_reg;

    logic rinc_raw;
    logic take_lo;
    logic emit_full;
    logic emit_flush;
    logic accept;
    logic ctr_clear;
    logic ctr_inc;
    logic ctr_terminal;

    drain_timeout_ctr #(
        .LIMIT (FLUSH_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (ctr_clear),
        .inc      (ctr_inc),
        .terminal (ctr_terminal)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LO;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and pop/emit decisions
    always_comb begin
        state_nx   = state;
        rinc_raw   = 1'b0;
        take_lo    = 1'b0;
        emit_full  = 1'b0;
        emit_flush = 1'b0;
        accept     = 1'b0;
        ctr_clear  = 1'b0;
        ctr_inc    = 1'b0;
        unique case (state)
            ST_LO: begin
                if (!fifo_empty) begin
                    rinc_raw  = 1'b1;
                    take_lo   = 1'b1;
                    ctr_clear = 1'b1;
                    state_nx  = ST_HI;
                end
            end
            ST_HI: begin
                // An arriving high nibble beats a flush due on the same cycle
                if (!fifo_empty) begin
                    rinc_raw  = 1'b1;
                    emit_full = 1'b1;
                    ctr_clear = 1'b1;
                    state_nx  = ST_HOLD;
                end else begin
                    ctr_inc = 1'b1;
                    if (ctr_terminal) begin
                        emit_flush = 1'b1;
                        state_nx   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    accept = 1'b1;
                    if (!fifo_empty) begin
                        rinc_raw  = 1'b1;
                        take_lo   = 1'b1;
                        ctr_clear = 1'b1;
                        state_nx  = ST_HI;
                    end else begin
                        state_nx  = ST_LO;
                    end
                end
            end
            default: begin
                state_nx = ST_LO;
            end
        endcase
    end

    // Pop strobe is suppressed while reset is asserted
    always_comb begin
        fifo_rinc = rinc_raw & ~rst;
    end

    // Held nibble and presented byte registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_reg      <= '0;
            out_data    <= '0;
            out_partial <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            if (take_lo) begin
                lo_reg <= fifo_rdata;
            end
            if (emit_full) begin
                out_data    <= {fifo_rdata, lo_reg};
                out_partial <= 1'b0;
                out_valid   <= 1'b1;
            end else if (emit_flush) begin
                out_data    <= {D_WIDTH'(0), lo_reg};
                out_partial <= 1'b1;
                out_valid   <= 1'b1;
            end else if (accept) begin
                out_valid   <= 1'b0;
            end
        end
    end

    // Accepted-byte counter, wrapping silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count <= '0;
        end else if (accept) begin
            byte_count <= byte_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_nibble_drain.sv
// Directed bench for fifo_nibble_drain with a show-ahead FIFO model.
module tb_fifo_nibble_drain;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic [3:0] fifo_rdata;
    logic       fifo_rinc;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_partial;
    logic [7:0] byte_count;

    // FIFO model: pushes from the stimulus process, pops on the DUT strobe
    logic [3:0] mem [0:2047];
    int         wp = 0;
    int         rp = 0;

    // Accepted-byte log and monitors
    logic [7:0] acc_data [0:1023];
    logic       acc_part [0:1023];
    int         n_acc = 0;
    int         viol  = 0;
    int         vcyc  = 0;

    int n_cmp = 0;
    int n_err = 0;

    assign fifo_empty = (wp == rp);
    assign fifo_rdata = mem[rp[10:0]];

    always #5 clk = ~clk;

    fifo_nibble_drain #(
        .D_WIDTH       (4),
        .FLUSH_TIMEOUT (16),
        .CNT_WIDTH     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rinc   (fifo_rinc),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_partial (out_partial),
        .byte_count  (byte_count)
    );

    always @(posedge clk) begin
        if (fifo_rinc && fifo_empty) viol <= viol + 1;
        if (fifo_rinc && !fifo_empty) rp <= rp + 1;
        if (out_valid) vcyc <= vcyc + 1;
        if (!rst && out_valid && out_ready) begin
            acc_data[n_acc] <= out_data;
            acc_part[n_acc] <= out_partial;
            n_acc           <= n_acc + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] nib);
        mem[wp[10:0]] = nib;
        wp = wp + 1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_rp;
        int base_acc;
        int base_v;
        int bad;
        int waited;

        // Reset, then an empty FIFO for 50 cycles
        step(3);
        check_eq("rst_rinc", fifo_rinc, 0);
        check_eq("rst_data", out_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            check_eq("idle_rinc", fifo_rinc, 0);
            check_eq("idle_valid", out_valid, 0);
            check_eq("idle_count", byte_count, 0);
        end

        // Back-to-back 0x3, 0xA with ready high
        out_ready = 1'b1;
        base_v = vcyc;
        push(4'h3);
        step(1);
        push(4'hA);
        step(1);
        check_eq("pair_valid", out_valid, 1);
        check_eq("pair_data", out_data, 8'hA3);
        check_eq("pair_partial", out_partial, 0);
        step(4);
        check_eq("pair_nacc", n_acc, 1);
        check_eq("pair_acc", acc_data[0], 8'hA3);
        check_eq("pair_vcyc", vcyc - base_v, 1);
        check_eq("pair_count", byte_count, 1);

        // Backpressure with 0x1,0x2,0x4,0x8 queued
        out_ready = 1'b0;
        base_rp = rp;
        push(4'h1); push(4'h2); push(4'h4); push(4'h8);
        step(2);
        for (int i = 0; i < 8; i++) begin
            check_eq("stall_data", out_data, 8'h21);
            check_eq("stall_valid", out_valid, 1);
            step(1);
        end
        check_eq("stall_pops", rp - base_rp, 2);
        out_ready = 1'b1;
        step(5);
        check_eq("bp_pops", rp - base_rp, 4);
        check_eq("bp_nacc", n_acc, 3);
        check_eq("bp_first", acc_data[1], 8'h21);
        check_eq("bp_second", acc_data[2], 8'h84);
        check_eq("bp_count", byte_count, 3);

        // Lone 0x5 flushed on the 16th empty cycle
        push(4'h5);
        step(16);
        check_eq("flush_early", out_valid, 0);
        step(1);
        check_eq("flush_valid", out_valid, 1);
        check_eq("flush_data", out_data, 8'h05);
        check_eq("flush_partial", out_partial, 1);
        step(3);
        check_eq("flush_count", byte_count, 4);

        // High nibble 0xC arrives on the 16th empty cycle: full byte wins
        push(4'h5);
        step(16);
        push(4'hC);
        step(1);
        check_eq("race_valid", out_valid, 1);
        check_eq("race_data", out_data, 8'hC5);
        check_eq("race_partial", out_partial, 0);
        step(3);
        check_eq("race_count", byte_count, 5);

        // Reset while holding 0x7; nibbles queued during reset must not pop
        push(4'h7);
        step(1);
        check_eq("hold7_valid", out_valid, 0);
        rst = 1'b1;
        push(4'h1); push(4'h2);
        base_rp = rp;
        #1;
        check_eq("rst_rinc_busy", fifo_rinc, 0);
        step(1);
        check_eq("rst_nopop", rp - base_rp, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_partial", out_partial, 0);
        check_eq("rst_data2", out_data, 0);
        check_eq("rst_count", byte_count, 0);
        rst = 1'b0;
        base_acc = n_acc;
        step(5);
        check_eq("post_rst_nacc", n_acc - base_acc, 1);
        check_eq("post_rst_data", acc_data[base_acc], 8'h21);
        check_eq("post_rst_part", acc_part[base_acc], 0);
        check_eq("post_rst_count", byte_count, 1);

        // Stream 257 bytes: counter wraps to 1
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        base_acc = n_acc;
        for (int k = 0; k < 514; k++) push(4'(k));
        waited = 0;
        while ((rp != wp || out_valid) && waited < 3000) begin
            step(1);
            waited++;
        end
        step(2);
        check_eq("wrap_done", (waited < 3000) ? 1 : 0, 1);
        check_eq("wrap_nacc", n_acc - base_acc, 257);
        check_eq("wrap_count", byte_count, 1);
        bad = 0;
        for (int j = 0; j < 257; j++) begin
            if (acc_data[base_acc + j] !== {4'(2 * j + 1), 4'(2 * j)} ||
                acc_part[base_acc + j] !== 1'b0) bad++;
        end
        check_eq("wrap_bytes", bad, 0);
        check_eq("wrap_last", acc_data[base_acc + 256], 8'h10);
        check_eq("rinc_when_empty", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
